line_sprite_scheduler: RTL and testbench

Per-scanline sprite scheduler for the runner game's line-buffered renderer. Once per row it decides which sprite slots (runner, cloud, score digits, obstacles) intersect the line being prepared into the back line buffer. For each active slot it produces the sprite-ROM row start address, which the pixel-rate line writer consumes. Sprite positions are snapshotted once per frame at the start of vertical blank, so no sprite tears mid-frame.

---
 rtl/line_sprite_scheduler_pkg.sv | 31 +++
 rtl/line_sprite_scheduler_if.sv | 35 +++
 rtl/line_sprite_scheduler_slot_tracker.sv | 93 +++++++++
 rtl/line_sprite_scheduler.sv | 95 +++++++++
 tb/tb_line_sprite_scheduler.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/line_sprite_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_sched_pkg
// Description : Shared types and defaults for the per-scanline sprite
//               scheduler (slot state, shadowed slot configuration).
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_sched_pkg;

  localparam int NUM_SLOTS_DEF = 4;
  localparam int VLINES_DEF    = 525;
  localparam int VISIBLE_DEF   = 480;
  localparam int ROW_W         = 10;
  localparam int ADDR_W        = 18;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } slot_state_t;

  typedef struct packed {
    logic              en;
    logic [ROW_W-1:0]  y;
    logic [7:0]        h;
    logic [7:0]        w;
    logic [ADDR_W-1:0] base;
  } slot_cfg_t;

endpackage
`default_nettype wire

// File: rtl/line_sprite_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : line_sprite_scheduler_if
// Description : Slot configuration inputs and per-line schedule outputs of
//               the sprite scheduler. master = game logic / line writer side,
//               slave = scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_sprite_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic [NUM_SLOTS-1:0]    slot_en;
  logic [NUM_SLOTS*10-1:0] slot_y;
  logic [NUM_SLOTS*8-1:0]  slot_h;
  logic [NUM_SLOTS*8-1:0]  slot_w;
  logic [NUM_SLOTS*18-1:0] slot_base;

  logic [9:0]              row;
  logic [9:0]              line_y;
  logic [NUM_SLOTS-1:0]    line_active;
  logic [NUM_SLOTS*18-1:0] line_addr;
  logic [2:0]              line_count;
  logic                    frame_latch;

  modport master (
    output slot_en, slot_y, slot_h, slot_w, slot_base,
    input  row, line_y, line_active, line_addr, line_count, frame_latch
  );

  modport slave (
    input  slot_en, slot_y, slot_h, slot_w, slot_base,
    output row, line_y, line_active, line_addr, line_count, frame_latch
  );
endinterface
`default_nettype wire

// File: rtl/line_sprite_scheduler_slot_tracker.sv
`default_nettype none
// ============================================================================
// Module      : sprite_slot_tracker
// Description : One sprite slot. Holds the per-frame shadow configuration and
//               walks the sprite-ROM row address while the sprite covers the
//               line being prepared.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_slot_tracker
  import sprite_sched_pkg::*;
#(
  parameter int VISIBLE = VISIBLE_DEF
) (
  input  logic              row_Clk,
  input  logic              Reset,
  input  slot_cfg_t         cfg_i,
  input  logic [ROW_W-1:0]  n_i,          // line being prepared after this edge
  input  logic              snapshot_i,
  output logic              active_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              active_nxt_o  // feeds the registered popcount
);

  localparam logic [ROW_W-1:0] c_VISIBLE = ROW_W'(VISIBLE);

  slot_cfg_t         cfg_q,       cfg_d;
  slot_state_t       state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [7:0]        rows_left_q, rows_left_d;
  logic              active_q;
  logic [ADDR_W-1:0] addr_out_q;

  // Next-state: snapshot reloads the shadow and rearms; otherwise step the slot.
  always_comb begin
    cfg_d       = cfg_q;
    state_d     = state_q;
    addr_d      = addr_q;
    rows_left_d = rows_left_q;
    if (snapshot_i) begin
      cfg_d   = cfg_i;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_q.en && (cfg_q.h != 8'd0) && (cfg_q.y < c_VISIBLE) &&
              (n_i == cfg_q.y)) begin
            state_d     = ACTIVE;
            addr_d      = cfg_q.base;
            rows_left_d = cfg_q.h;
          end
        end
        ACTIVE: begin
          // Last sprite row already shown, or sprite runs off the bottom.
          if ((rows_left_q == 8'd1) || (n_i >= c_VISIBLE)) begin
            state_d = DONE;
          end else begin
            // Width doubles as the ROM row stride; 18-bit wrap is intended.
            addr_d      = addr_q + {{(ADDR_W-8){1'b0}}, cfg_q.w};
            rows_left_d = rows_left_q - 8'd1;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign active_nxt_o = (state_d == ACTIVE);

  // Slot state and registered outputs; address is forced to 0 when inactive.
  always_ff @(posedge row_Clk or posedge Reset) begin
    if (Reset) begin
      cfg_q       <= '0;
      state_q     <= IDLE;
      addr_q      <= '0;
      rows_left_q <= '0;
      active_q    <= 1'b0;
      addr_out_q  <= '0;
    end else begin
      cfg_q       <= cfg_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      rows_left_q <= rows_left_d;
      active_q    <= (state_d == ACTIVE);
      addr_out_q  <= (state_d == ACTIVE) ? addr_d : '0;
    end
  end

  assign active_o = active_q;
  assign addr_o   = addr_out_q;

endmodule
`default_nettype wire

// File: rtl/line_sprite_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : line_sprite_scheduler
// Description : Per-scanline sprite scheduler. Row counter, once-per-frame
//               snapshot strobe at the start of vertical blank, one tracker
//               per slot, and the registered active-slot popcount.
// Revision    : 1.0 - initial release
// ============================================================================
module line_sprite_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int VLINES    = VLINES_DEF,
  parameter int VISIBLE   = VISIBLE_DEF
) (
  input  logic                    row_Clk,
  input  logic                    Reset,
  line_sprite_scheduler_if.slave  bus
);

  localparam logic [ROW_W-1:0] c_LAST    = ROW_W'(VLINES - 1);
  localparam logic [ROW_W-1:0] c_VISIBLE = ROW_W'(VISIBLE);

  logic [ROW_W-1:0]            row_q,    row_d;
  logic [ROW_W-1:0]            line_y_q, line_y_d;
  logic                        frame_latch_q;
  logic [2:0]                  line_count_q, line_count_d;
  logic                        w_snapshot;
  logic [NUM_SLOTS-1:0]        w_active;
  logic [NUM_SLOTS-1:0]        w_active_nxt;
  logic [NUM_SLOTS*ADDR_W-1:0] w_addr;

  // Next row, the line it prepares, and the vertical-blank snapshot strobe.
  always_comb begin
    row_d      = (row_q == c_LAST) ? '0 : row_q + 10'd1;
    line_y_d   = (row_d == c_LAST) ? '0 : row_d + 10'd1;
    w_snapshot = (row_d == c_VISIBLE);
  end

  // Population count of the slots that will be active after this edge.
  always_comb begin
    line_count_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      line_count_d = line_count_d + {2'b00, w_active_nxt[i]};
    end
  end

  // Row counter and frame-level output registers.
  always_ff @(posedge row_Clk or posedge Reset) begin
    if (Reset) begin
      row_q         <= '0;
      line_y_q      <= 10'd1;
      frame_latch_q <= 1'b0;
      line_count_q  <= '0;
    end else begin
      row_q         <= row_d;
      line_y_q      <= line_y_d;
      frame_latch_q <= w_snapshot;
      line_count_q  <= line_count_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      slot_cfg_t w_cfg;
      assign w_cfg.en   = bus.slot_en[i];
      assign w_cfg.y    = bus.slot_y[i*10 +: 10];
      assign w_cfg.h    = bus.slot_h[i*8 +: 8];
      assign w_cfg.w    = bus.slot_w[i*8 +: 8];
      assign w_cfg.base = bus.slot_base[i*18 +: 18];

      sprite_slot_tracker #(
        .VISIBLE (VISIBLE)
      ) u_tracker (
        .row_Clk      (row_Clk),
        .Reset        (Reset),
        .cfg_i        (w_cfg),
        .n_i          (line_y_d),
        .snapshot_i   (w_snapshot),
        .active_o     (w_active[i]),
        .addr_o       (w_addr[i*ADDR_W +: ADDR_W]),
        .active_nxt_o (w_active_nxt[i])
      );
    end
  endgenerate

  assign bus.row         = row_q;
  assign bus.line_y      = line_y_q;
  assign bus.line_active = w_active;
  assign bus.line_addr   = w_addr;
  assign bus.line_count  = line_count_q;
  assign bus.frame_latch = frame_latch_q;

endmodule
`default_nettype wire

// File: tb/tb_line_sprite_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_sprite_scheduler
// Description : Directed self-checking bench for line_sprite_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_sprite_scheduler;

  logic row_Clk;
  logic Reset;

  line_sprite_scheduler_if #(.NUM_SLOTS(4)) bus ();

  line_sprite_scheduler #(
    .NUM_SLOTS (4),
    .VLINES    (525),
    .VISIBLE   (480)
  ) dut (
    .row_Clk (row_Clk),
    .Reset   (Reset),
    .bus     (bus)
  );

  initial row_Clk = 1'b0;
  always #5 row_Clk = ~row_Clk;

  int   total;
  int   passed;
  int   exp_r;        // bench's own row model
  bit   mon1, mon3;   // watch windows for the never-active slots
  logic sticky1, sticky3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d (row model %0d)", tag, obs, exp, exp_r);
  endtask

  // Advance one row, sample 1 time unit after the edge.
  task automatic tick();
    @(posedge row_Clk);
    #1;
    exp_r = (exp_r + 1) % 525;
    if (mon1) sticky1 = sticky1 | bus.line_active[1];
    if (mon3) sticky3 = sticky3 | bus.line_active[3];
  endtask

  task automatic run_to(input int target);
    tick();
    while (exp_r != target) tick();
  endtask

  task automatic set_slot(input int i, input logic en, input logic [9:0] y,
                          input logic [7:0] h, input logic [7:0] w,
                          input logic [17:0] base);
    bus.slot_en[i]          = en;
    bus.slot_y[i*10 +: 10]  = y;
    bus.slot_h[i*8 +: 8]    = h;
    bus.slot_w[i*8 +: 8]    = w;
    bus.slot_base[i*18 +: 18] = base;
  endtask

  initial begin
    total = 0; passed = 0; exp_r = 0;
    mon1 = 0; mon3 = 0; sticky1 = 0; sticky3 = 0;
    Reset = 1'b1;
    set_slot(0, 1'b1, 10'd100, 8'd3,  8'd88, 18'd1000);
    set_slot(1, 1'b1, 10'd0,   8'd2,  8'd16, 18'd5000);
    set_slot(2, 1'b1, 10'd478, 8'd10, 8'd20, 18'd2000);
    set_slot(3, 1'b0, 10'd50,  8'd5,  8'd8,  18'd700);

    // Power-on reset values
    repeat (3) @(posedge row_Clk);
    #1;
    chk("rst_row",    bus.row, 0);
    chk("rst_line_y", bus.line_y, 1);
    chk("rst_active", bus.line_active, 0);
    chk("rst_addr",   bus.line_addr, 0);
    chk("rst_count",  bus.line_count, 0);
    chk("rst_latch",  bus.frame_latch, 0);
    @(negedge row_Clk);
    Reset = 1'b0;
    exp_r = 0;

    // Mid-frame asynchronous reset
    run_to(200);
    chk("run_row",    bus.row, 200);
    chk("run_line_y", bus.line_y, 201);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_row",    bus.row, 0);
    chk("mid_rst_line_y", bus.line_y, 1);
    chk("mid_rst_count",  bus.line_count, 0);
    @(negedge row_Clk);
    Reset = 1'b0;
    exp_r = 0;

    // First frame stays blank until the snapshot
    run_to(99);
    chk("pre_snap_active", bus.line_active, 0);
    run_to(479);
    chk("pre_snap_latch", bus.frame_latch, 0);
    run_to(480);
    chk("snap1_latch",  bus.frame_latch, 1);
    chk("snap1_active", bus.line_active, 0);
    mon3 = 1;
    run_to(481);
    chk("post_snap_latch", bus.frame_latch, 0);

    // Top-row sprite in slot 1 prepared on the last row of the frame
    run_to(524);
    chk("top_row",    bus.row, 524);
    chk("top_line_y", bus.line_y, 0);
    chk("top_active", bus.line_active, 4'b0010);
    chk("top_addr_a", bus.line_addr[18 +: 18], 5000);
    run_to(0);
    chk("top_addr_b", bus.line_addr[18 +: 18], 5016);
    chk("top_count",  bus.line_count, 1);
    run_to(1);
    chk("top_done_active", bus.line_active, 0);
    chk("top_done_addr",   bus.line_addr[18 +: 18], 0);

    // Single sprite: y=100 h=3 w=88 base=1000
    run_to(98);
    chk("s0_before", bus.line_active, 0);
    run_to(99);
    chk("s0_active_99", bus.line_active, 4'b0001);
    chk("s0_line_y_99", bus.line_y, 100);
    chk("s0_addr_99",   bus.line_addr[17:0], 1000);
    chk("s0_count_99",  bus.line_count, 1);
    run_to(100);
    chk("s0_addr_100",  bus.line_addr[17:0], 1088);
    run_to(101);
    chk("s0_addr_101",  bus.line_addr[17:0], 1176);
    run_to(102);
    chk("s0_active_102", bus.line_active, 0);
    chk("s0_addr_102",   bus.line_addr[17:0], 0);

    // Input change mid-frame must wait for the next snapshot
    run_to(150);
    set_slot(0, 1'b1, 10'd200, 8'd3, 8'd88, 18'd1000);

    // Bottom clip: y=478 h=10
    run_to(476);
    chk("clip_before", bus.line_active, 0);
    run_to(477);
    chk("clip_active_477", bus.line_active, 4'b0100);
    chk("clip_addr_477",   bus.line_addr[36 +: 18], 2000);
    run_to(478);
    chk("clip_addr_478",   bus.line_addr[36 +: 18], 2020);
    run_to(479);
    chk("clip_active_479", bus.line_active, 0);
    chk("clip_addr_479",   bus.line_addr[36 +: 18], 0);
    chk("clip_count_479",  bus.line_count, 0);
    run_to(480);
    chk("snap2_latch", bus.frame_latch, 1);

    // Second frame uses the y=200 snapshot
    run_to(99);
    chk("iso_old_y", bus.line_active[0], 0);
    run_to(199);
    chk("iso_new_y_active", bus.line_active[0], 1);
    chk("iso_new_y_addr",   bus.line_addr[17:0], 1000);
    run_to(202);
    chk("iso_new_y_done", bus.line_active[0], 0);

    // Configure overlap frame: slots 0, 2, 3 all cover line 50; slot 1 h=0
    run_to(300);
    set_slot(0, 1'b1, 10'd48, 8'd5, 8'd10, 18'd100);
    set_slot(1, 1'b1, 10'd0,  8'd0, 8'd16, 18'd5000);
    set_slot(2, 1'b1, 10'd50, 8'd1, 8'd4,  18'd300);
    set_slot(3, 1'b1, 10'd49, 8'd3, 8'd8,  18'd400);
    run_to(480);
    mon3 = 0;
    chk("never_en0_two_frames", sticky3, 0);
    chk("snap3_latch", bus.frame_latch, 1);
    mon1 = 1;

    run_to(49);
    chk("ovl_active", bus.line_active, 4'b1101);
    chk("ovl_count",  bus.line_count, 3);
    chk("ovl_addr0",  bus.line_addr[0 +: 18], 120);
    chk("ovl_addr1",  bus.line_addr[18 +: 18], 0);
    chk("ovl_addr2",  bus.line_addr[36 +: 18], 300);
    chk("ovl_addr3",  bus.line_addr[54 +: 18], 408);
    run_to(50);
    chk("ovl_active_50", bus.line_active, 4'b1001);
    chk("ovl_count_50",  bus.line_count, 2);

    // Next frame: slot 1 off-screen at y=500
    run_to(300);
    set_slot(1, 1'b1, 10'd500, 8'd2, 8'd16, 18'd5000);
    run_to(480);
    run_to(479);
    mon1 = 0;
    chk("never_h0_y500_two_frames", sticky1, 0);
    run_to(480);
    chk("snap5_latch", bus.frame_latch, 1);
    chk("snap5_row",   bus.row, 480);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
